// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the round-robin ALU scheduler slice:
//   - DATA_W / SEL_W  : ALU datapath and op-select widths
//   - ALU_ADD..ALU_CMP: op-select encodings understood by the alu block
//   - state_t         : scheduler FSM states (IDLE / EXEC / RESP)
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 3;

    localparam logic [SEL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [SEL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [SEL_W-1:0] ALU_AND = 3'b010;
    localparam logic [SEL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [SEL_W-1:0] ALU_XOR = 3'b100;
    localparam logic [SEL_W-1:0] ALU_SHL = 3'b101;
    localparam logic [SEL_W-1:0] ALU_SHR = 3'b110;
    localparam logic [SEL_W-1:0] ALU_CMP = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational 16-bit ALU shared by all requesters.
// Ports:
//   i_a, i_b : operands (DATA_W bits)
//   i_sel    : op select (SEL_W bits), see ALU_* in alu_pkg
//   o_y      : result (DATA_W bits)
// Add/sub wrap modulo 2^DATA_W; shifts are logical by i_b mod 16;
// compare returns 0 (equal), 1 (a > b unsigned) or 2 (a < b).
// -----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [SEL_W-1:0]  i_sel,
    output logic [DATA_W-1:0] o_y
);

    always_comb begin
        o_y = '0;
        case (i_sel)
            ALU_ADD: o_y = i_a + i_b;
            ALU_SUB: o_y = i_a - i_b;
            ALU_AND: o_y = i_a & i_b;
            ALU_OR:  o_y = i_a | i_b;
            ALU_XOR: o_y = i_a ^ i_b;
            ALU_SHL: o_y = i_a << i_b[3:0];
            ALU_SHR: o_y = i_a >> i_b[3:0];
            ALU_CMP: begin
                if (i_a == i_b)
                    o_y = '0;
                else if (i_a > i_b)
                    o_y = DATA_W'(1);
                else
                    o_y = DATA_W'(2);
            end
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant. Searches i_req starting at i_ptr and
// wrapping around; the first asserted request wins.
// Ports:
//   i_req : request vector (N bits)
//   i_ptr : highest-priority index this cycle (IW bits, must be < N)
//   o_gnt : one-hot grant, zero when no request
//   o_idx : encoded index of the granted request (0 when none)
//   o_any : at least one request is asserted
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // i_ptr + k reduced modulo N; both terms are < N so one subtraction suffices.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N)
            s = s - N;
        return IW'(s);
    endfunction

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!o_any && i_req[wrap_add(i_ptr, k)]) begin
                o_gnt[wrap_add(i_ptr, k)] = 1'b1;
                o_idx                     = wrap_add(i_ptr, k);
                o_any                     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rr_sched.sv
// -----------------------------------------------------------------------------
// alu_rr_sched
// Round-robin scheduler sharing one combinational ALU between NUM_REQ clients.
// One operation is in flight at a time: IDLE (grant/accept) -> EXEC (ALU
// evaluates registered operands) -> RESP (registered result held until taken).
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   req_valid / req_ready  : per-requester handshake (ready one-hot or zero)
//   req_a, req_b           : packed 16-bit operands, requester i at [16*i +: 16]
//   req_sel                : packed 3-bit op selects, requester i at [3*i +: 3]
//   rsp_valid / rsp_ready  : result handshake
//   rsp_data, rsp_id       : result and owning requester index
// Optional build macro ALU_RR_SCHED_PERF_EN adds perf_grants (NUM_REQ*16):
// one saturating 16-bit accept counter per requester.
// -----------------------------------------------------------------------------
module alu_rr_sched
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id
`ifdef ALU_RR_SCHED_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0]     perf_grants
`endif
);

    state_t              r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [SEL_W-1:0]    r_sel;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [ID_W-1:0]     r_rsp_id;

    logic [NUM_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]     w_gnt_idx;
    logic                w_gnt_any;
    logic                w_accept;
    logic [ID_W-1:0]     w_ptr_nxt;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [SEL_W-1:0]    w_sel;
    logic [DATA_W-1:0]   w_alu_y;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_any (w_gnt_any)
    );

    // Grants are only visible in IDLE; reset_n gating keeps req_ready low
    // while reset is held even if requesters are already asserting valid.
    assign req_ready = (reset_n && (r_state == IDLE)) ? w_gnt : '0;
    assign w_accept  = (r_state == IDLE) && w_gnt_any;
    assign w_ptr_nxt = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);

    // Grant is one-hot, so the payload mux is a simple priority-free select.
    always_comb begin
        w_a   = '0;
        w_b   = '0;
        w_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_a   = req_a[DATA_W*i +: DATA_W];
                w_b   = req_b[DATA_W*i +: DATA_W];
                w_sel = req_sel[SEL_W*i +: SEL_W];
            end
        end
    end

    alu u_alu (
        .i_a   (r_a),
        .i_b   (r_b),
        .i_sel (r_sel),
        .o_y   (w_alu_y)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sel       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_a;
                        r_b     <= w_b;
                        r_sel   <= w_sel;
                        r_id    <= w_gnt_idx;
                        r_ptr   <= w_ptr_nxt;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_data  <= w_alu_y;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    // rsp_data/rsp_id deliberately keep their value after the handshake.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;

`ifdef ALU_RR_SCHED_PERF_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
        logic [15:0] r_cnt;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                r_cnt <= '0;
            else if (w_accept && w_gnt[i])
                r_cnt <= sat_inc(r_cnt);
        end
        assign perf_grants[16*i +: 16] = r_cnt;
    end
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_rr_sched
// Self-checking bench for alu_rr_sched with NUM_REQ=3. Directed steps cover
// reset values, single op, arithmetic edge cases, back-pressure, reset during
// EXEC/RESP and strict rotation; a randomized phase is scored against a
// transaction-level model (grant rule, ALU arithmetic, response queue).
// Perf-counter steps are built only with ALU_RR_SCHED_PERF_EN.
// -----------------------------------------------------------------------------
module tb_alu_rr_sched;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [15:0]     a_arr [N];
    logic [15:0]     b_arr [N];
    logic [2:0]      s_arr [N];
    logic [N*16-1:0] req_a;
    logic [N*16-1:0] req_b;
    logic [N*3-1:0]  req_sel;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [15:0]     rsp_data;
    logic [1:0]      rsp_id;
`ifdef ALU_RR_SCHED_PERF_EN
    logic [N*16-1:0] perf_grants;
`endif

    always #5 clk = ~clk;

    assign req_a   = {a_arr[2], a_arr[1], a_arr[0]};
    assign req_b   = {b_arr[2], b_arr[1], b_arr[0]};
    assign req_sel = {s_arr[2], s_arr[1], s_arr[0]};

    alu_rr_sched #(
        .NUM_REQ (N),
        .ID_W    (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
`ifdef ALU_RR_SCHED_PERF_EN
        ,
        .perf_grants (perf_grants)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int m_ptr = 0;

    typedef struct {
        int          id;
        logic [15:0] d;
    } exp_t;
    exp_t q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU written from the operation definitions with plain integers.
    function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b, input logic [2:0] sel);
        int unsigned ua, ub, r;
        ua = a;
        ub = b;
        case (sel)
            3'd0:    r = (ua + ub) % 65536;
            3'd1:    r = (ua + 65536 - ub) % 65536;
            3'd2:    r = ua & ub;
            3'd3:    r = ua | ub;
            3'd4:    r = ua ^ ub;
            3'd5:    r = (ua << (ub % 16)) % 65536;
            3'd6:    r = ua >> (ub % 16);
            default: r = (ua == ub) ? 0 : ((ua > ub) ? 1 : 2);
        endcase
        return r[15:0];
    endfunction

    // First valid requester at or after ptr, wrapping; -1 if none.
    function automatic int ref_grant(input int ptr, input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [31:0] onehot(input int g);
        return (g < 0) ? 32'd0 : (32'd1 << g);
    endfunction

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        #2;
        @(negedge clk);
        reset_n = 1'b1;
        m_ptr   = 0;
        tick();
    endtask

    // Single requester issues one op with rsp_ready high; checks full timeline.
    task automatic run_op(input int id, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] sel, input string tag, input logic [15:0] exp);
        req_valid    = '0;
        a_arr[id]    = a;
        b_arr[id]    = b;
        s_arr[id]    = sel;
        req_valid[id] = 1'b1;
        #1;
        check({tag, " ready"}, req_ready, onehot(id));
        tick();
        req_valid = '0;
        m_ptr     = (id + 1) % N;
        check({tag, " exec valid"}, rsp_valid, 0);
        check({tag, " exec ready"}, req_ready, 0);
        tick();
        check({tag, " valid"}, rsp_valid, 1);
        check({tag, " data"}, rsp_data, exp);
        check({tag, " id"}, rsp_id, id);
        tick();
        check({tag, " done"}, rsp_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq [6];
        logic [15:0] exp_d;
        int          g;
        int          age;
        bit          outstanding;
        bit          stall_prev;
        logic [15:0] hold_d;
        int          hold_id;
        bit          hs;

        seq = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < N; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
            s_arr[i] = '0;
        end
        rsp_ready = 1'b1;
        req_valid = '1;
        reset_n   = 1'b0;
        #12;
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_data", rsp_data, 0);
        check("reset rsp_id", rsp_id, 0);
        check("reset req_ready", req_ready, 0);
        req_valid = '0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // ---- single op and arithmetic edges
        run_op(0, 16'h0003, 16'h0004, 3'd0, "single add", 16'h0007);
        run_op(1, 16'h0000, 16'h0001, 3'd1, "sub wrap", 16'hFFFF);
        run_op(2, 16'h0001, 16'h0013, 3'd5, "shl mod16", 16'h0008);
        run_op(0, 16'h8000, 16'h0010, 3'd6, "shr mod16", 16'h8000);
        run_op(1, 16'h0005, 16'h0009, 3'd7, "cmp lt", 16'h0002);
        run_op(2, 16'h0007, 16'h0007, 3'd7, "cmp eq", 16'h0000);
        run_op(0, 16'h0009, 16'h0005, 3'd7, "cmp gt", 16'h0001);
        run_op(1, 16'hFFFF, 16'h0002, 3'd0, "add wrap", 16'h0001);
        run_op(2, 16'hF0F0, 16'hFF00, 3'd2, "and", 16'hF000);
        run_op(0, 16'hF0F0, 16'h0F0F, 3'd3, "or", 16'hFFFF);

        // ---- back-pressure in RESP
        rsp_ready    = 1'b0;
        a_arr[1]     = 16'h1234;
        b_arr[1]     = 16'h00FF;
        s_arr[1]     = 3'd4;
        req_valid    = 3'b010;
        #1;
        check("bp ready", req_ready, 3'b010);
        tick();
        req_valid = '0;
        tick();
        a_arr[2]     = 16'h00AA;
        b_arr[2]     = 16'h0055;
        s_arr[2]     = 3'd3;
        req_valid[2] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("bp hold valid", rsp_valid, 1);
            check("bp hold data", rsp_data, 16'h12CB);
            check("bp hold id", rsp_id, 1);
            check("bp hold ready", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp released valid", rsp_valid, 0);
        check("bp keeps data", rsp_data, 16'h12CB);
        check("bp resume ready", req_ready, 3'b100);
        tick();
        req_valid = '0;
        tick();
        check("bp next data", rsp_data, 16'h00FF);
        check("bp next id", rsp_id, 2);
        tick();

        // ---- reset during EXEC
        a_arr[0]  = 16'h0005;
        b_arr[0]  = 16'h0006;
        s_arr[0]  = 3'd0;
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        #2;
        reset_n = 1'b0;
        #1;
        check("rst exec rsp_data", rsp_data, 0);
        check("rst exec rsp_id", rsp_id, 0);
        check("rst exec rsp_valid", rsp_valid, 0);
        check("rst exec req_ready", req_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        m_ptr   = 0;
        tick();
        for (int c = 0; c < 3; c++) begin
            check("rst exec no stale rsp", rsp_valid, 0);
            tick();
        end
        req_valid = 3'b011;
        #1;
        check("rst exec grant req0", req_ready, 3'b001);
        tick();
        req_valid = '0;
        tick();
        check("rst exec op data", rsp_data, 16'h000B);
        tick();

        // ---- reset during RESP
        rsp_ready = 1'b0;
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        tick();
        check("rst resp pre valid", rsp_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst resp valid", rsp_valid, 0);
        check("rst resp data", rsp_data, 0);
        @(negedge clk);
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        tick();
        check("rst resp no stale", rsp_valid, 0);
        tick();

        // ---- strict rotation with all requesters valid
        do_reset();
        for (int i = 0; i < N; i++) begin
            a_arr[i] = 16'(16'h0100 * (i + 1));
            b_arr[i] = 16'(i);
            s_arr[i] = 3'd0;
        end
        req_valid = 3'b111;
        #1;
        for (int k = 0; k < 6; k++) begin
            check("rot ready", req_ready, onehot(seq[k]));
            tick();
            check("rot exec valid", rsp_valid, 0);
            tick();
            check("rot valid", rsp_valid, 1);
            check("rot id", rsp_id, seq[k]);
            check("rot data", rsp_data, ref_alu(a_arr[seq[k]], b_arr[seq[k]], 3'd0));
            tick();
        end
        req_valid = '0;

        // ---- randomized traffic against the transaction model
        do_reset();
        q.delete();
        outstanding = 0;
        stall_prev  = 0;
        age         = 0;
        hold_d      = '0;
        hold_id     = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        a_arr[i]     = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
                        b_arr[i]     = ($urandom_range(0, 5) == 0) ? a_arr[i] : 16'($urandom);
                        s_arr[i]     = 3'($urandom_range(0, 7));
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = outstanding ? -1 : ref_grant(m_ptr, req_valid);
            check("rnd ready", req_ready, onehot(g));
            if (outstanding)
                check("rnd rsp_valid timing", rsp_valid, (age >= 1) ? 1 : 0);
            else
                check("rnd idle rsp_valid", rsp_valid, 0);
            if (stall_prev) begin
                check("rnd stall data", rsp_data, hold_d);
                check("rnd stall id", rsp_id, hold_id);
            end
            hs = rsp_valid && rsp_ready;
            if (hs) begin
                if (q.size() == 0) begin
                    check("rnd spurious rsp", rsp_valid, 0);
                end else begin
                    check("rnd rsp data", rsp_data, q[0].d);
                    check("rnd rsp id", rsp_id, q[0].id);
                    void'(q.pop_front());
                end
            end
            stall_prev = rsp_valid && !rsp_ready;
            hold_d     = rsp_data;
            hold_id    = int'(rsp_id);
            tick();
            age++;
            if (g >= 0) begin
                q.push_back('{g, ref_alu(a_arr[g], b_arr[g], s_arr[g])});
                m_ptr        = (g + 1) % N;
                outstanding  = 1;
                age          = 0;
                req_valid[g] = 1'b0;
            end
            if (hs)
                outstanding = 0;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid && q.size() != 0) begin
                check("drain data", rsp_data, q[0].d);
                check("drain id", rsp_id, q[0].id);
                void'(q.pop_front());
            end
            tick();
        end
        check("drain queue empty", q.size(), 0);
        check("drain rsp_valid", rsp_valid, 0);

`ifdef ALU_RR_SCHED_PERF_EN
        // ---- grant counters
        do_reset();
        check("perf reset", perf_grants, 0);
        run_op(1, 16'h0001, 16'h0001, 3'd0, "perf r1 a", 16'h0002);
        run_op(1, 16'h0002, 16'h0001, 3'd0, "perf r1 b", 16'h0003);
        run_op(1, 16'h0003, 16'h0001, 3'd0, "perf r1 c", 16'h0004);
        check("perf req1 count", perf_grants[31:16], 3);
        check("perf req0 count", perf_grants[15:0], 0);
        force dut.g_perf[0].r_cnt = 16'hFFFF;
        #1;
        release dut.g_perf[0].r_cnt;
        run_op(0, 16'h0001, 16'h0001, 3'd0, "perf sat op", 16'h0002);
        check("perf saturate", perf_grants[15:0], 16'hFFFF);
        check("perf req1 hold", perf_grants[31:16], 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
